// File: rtl/watch_ctrl_pkg.sv
// Shared encodings for the watch edit controller: FSM states and button indices.
package watch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for the four debounced buttons; previous levels reset to ones
// so a button held through reset never reports an edge.
module btn_edge_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_btn,
  output logic [3:0] o_rise
);

  logic [3:0] r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= '1;
    else     r_prev <= i_btn;
  end

  assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/watch_edit_controller.sv
// Watch RUN/EDIT control FSM with cursor and one-hot inc/dec pulses.
// Optional hold-to-auto-repeat on up/down when WATCH_EDIT_AUTOREPEAT_EN is defined.
//
// state     | meaning
// ST_RUN    | time counting, run=1
// ST_EDIT   | cursor moves, single inc/dec pulses
// ST_HOLD   | up/down held after first pulse, waiting REPEAT_DLY
// ST_REPEAT | auto-repeat, one pulse every REPEAT_PER cycles
module watch_edit_controller
  import watch_ctrl_pkg::*;
#(
  parameter  int NUM_FIELDS = 6,
  parameter  int REPEAT_DLY = 50_000_000,
  parameter  int REPEAT_PER = 10_000_000,
  localparam int SEL_W      = $clog2(NUM_FIELDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_r,
  input  logic                  btn_l,
  input  logic                  btn_u,
  input  logic                  btn_d,
  input  logic                  edit_en,
  input  logic                  stopwatch_mode,
  output logic                  run,
  output logic                  editing,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_FIELDS-1:0] inc,
  output logic [NUM_FIELDS-1:0] dec
);

  state_t                r_state;
  logic                  r_run;
  logic                  r_editing;
  logic [SEL_W-1:0]      r_sel;
  logic [NUM_FIELDS-1:0] r_inc;
  logic [NUM_FIELDS-1:0] r_dec;

  logic [3:0]            w_rise;
  logic                  w_mode_ok;
  logic [SEL_W-1:0]      w_sel_dn;
  logic [SEL_W-1:0]      w_sel_up;
  logic [NUM_FIELDS-1:0] w_onehot;

  btn_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_btn  ({btn_d, btn_u, btn_l, btn_r}),
    .o_rise (w_rise)
  );

  assign w_mode_ok = edit_en & ~stopwatch_mode;
  assign w_sel_dn  = (r_sel == '0) ? SEL_W'(NUM_FIELDS - 1) : r_sel - 1'b1;
  assign w_sel_up  = (r_sel == SEL_W'(NUM_FIELDS - 1)) ? '0 : r_sel + 1'b1;
  assign w_onehot  = NUM_FIELDS'(1) << r_sel;

`ifdef WATCH_EDIT_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_hold_dn;
  logic             w_held;
  logic             w_tc;

  assign w_held = r_hold_dn ? btn_d : btn_u;
  assign w_tc   = (r_state == ST_HOLD) ? (r_cnt == CNT_W'(REPEAT_DLY - 1))
                                       : (r_cnt == CNT_W'(REPEAT_PER - 1));
`else
  logic w_unused_repeat;
  assign w_unused_repeat = ^{REPEAT_DLY, REPEAT_PER};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_run     <= 1'b0;
      r_editing <= 1'b0;
      r_sel     <= '0;
      r_inc     <= '0;
      r_dec     <= '0;
`ifdef WATCH_EDIT_AUTOREPEAT_EN
      r_cnt     <= '0;
      r_hold_dn <= 1'b0;
`endif
    end else begin
      r_inc <= '0;
      r_dec <= '0;
      case (r_state)
        ST_RUN: begin
          if (w_mode_ok) begin
            r_state   <= ST_EDIT;
            r_sel     <= '0;
            r_run     <= 1'b0;
            r_editing <= 1'b1;
          end else begin
            r_run     <= 1'b1;
            r_editing <= 1'b0;
          end
        end
        ST_EDIT: begin
          if (!w_mode_ok) begin
            r_state   <= ST_RUN;
            r_run     <= 1'b1;
            r_editing <= 1'b0;
          end else if (w_rise[BTN_R]) begin
            r_sel <= w_sel_dn;
          end else if (w_rise[BTN_L]) begin
            r_sel <= w_sel_up;
          end else if (w_rise[BTN_U]) begin
            r_inc <= w_onehot;
`ifdef WATCH_EDIT_AUTOREPEAT_EN
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_hold_dn <= 1'b0;
`endif
          end else if (w_rise[BTN_D]) begin
            r_dec <= w_onehot;
`ifdef WATCH_EDIT_AUTOREPEAT_EN
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_hold_dn <= 1'b1;
`endif
          end
        end
`ifdef WATCH_EDIT_AUTOREPEAT_EN
        ST_HOLD, ST_REPEAT: begin
          if (!w_mode_ok) begin
            r_state   <= ST_RUN;
            r_run     <= 1'b1;
            r_editing <= 1'b0;
          end else if (|w_rise) begin
            // any new edge aborts the repeat; cursor edges still take effect
            r_state <= ST_EDIT;
            if (w_rise[BTN_R])      r_sel <= w_sel_dn;
            else if (w_rise[BTN_L]) r_sel <= w_sel_up;
          end else if (!w_held) begin
            r_state <= ST_EDIT;
          end else if (w_tc) begin
            r_state <= ST_REPEAT;
            r_cnt   <= '0;
            if (r_hold_dn) r_dec <= w_onehot;
            else           r_inc <= w_onehot;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        default: begin
          r_state   <= ST_RUN;
          r_run     <= 1'b1;
          r_editing <= 1'b0;
        end
      endcase
    end
  end

  assign run     = r_run;
  assign editing = r_editing;
  assign sel     = r_sel;
  assign inc     = r_inc;
  assign dec     = r_dec;

endmodule

// File: tb/tb_watch_edit_controller.sv
// Scoreboard bench for watch_edit_controller: expected pulses are queued by the
// stimulus and matched by a monitor whenever inc/dec is nonzero.
module tb_watch_edit_controller;

  localparam int NF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_r = 1'b0, btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic       edit_en = 1'b0, stopwatch_mode = 1'b0;
  logic       run, editing;
  logic [2:0] sel;
  logic [NF-1:0] inc, dec;

  watch_edit_controller #(
    .NUM_FIELDS (NF),
    .REPEAT_DLY (8),
    .REPEAT_PER (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_r          (btn_r),
    .btn_l          (btn_l),
    .btn_u          (btn_u),
    .btn_d          (btn_d),
    .edit_en        (edit_en),
    .stopwatch_mode (stopwatch_mode),
    .run            (run),
    .editing        (editing),
    .sel            (sel),
    .inc            (inc),
    .dec            (dec)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [NF-1:0] inc;
    logic [NF-1:0] dec;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void expect_pulse(int off, logic [NF-1:0] i, logic [NF-1:0] d);
    exp_t e;
    e.cyc = cyc + off;
    e.inc = i;
    e.dec = d;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && (inc != '0 || dec != '0)) begin
      chk("pulse_onehot", int'($countones({inc, dec})), 1);
      if (q.size() == 0) begin
        chk("unexpected_pulse", int'({inc, dec}), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_inc", int'(inc), int'(e.inc));
        chk("pulse_dec", int'(dec), int'(e.dec));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_r(); btn_r = 1'b1; tick(); btn_r = 1'b0; tick(); endtask
  task automatic press_l(); btn_l = 1'b1; tick(); btn_l = 1'b0; tick(); endtask

  initial begin
    // reset with btn_u held and edit_en on
    btn_u   = 1'b1;
    edit_en = 1'b1;
    tick(3);
    chk("rst_run", int'(run), 0);
    chk("rst_editing", int'(editing), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_pulses", int'({inc, dec}), 0);
    rst = 1'b0;
    tick();
    chk("enter_edit_editing", int'(editing), 1);
    chk("enter_edit_run", int'(run), 0);
    chk("enter_edit_sel", int'(sel), 0);
    tick(4);
    btn_u = 1'b0;
    tick(2);
    btn_u = 1'b1;
    expect_pulse(1, 6'b000001, 6'b0);
    tick();
    btn_u = 1'b0;
    tick(3);

    // cursor wrap and increment at sel=1
    press_r();
    chk("sel_wrap_down", int'(sel), 5);
    press_l();
    chk("sel_wrap_up", int'(sel), 0);
    press_l();
    chk("sel_after_2l", int'(sel), 1);
    btn_u = 1'b1;
    expect_pulse(1, 6'b000010, 6'b0);
    tick();
    btn_u = 1'b0;
    tick(3);

    // U and D same cycle: inc only
    btn_u = 1'b1; btn_d = 1'b1;
    expect_pulse(1, 6'b000010, 6'b0);
    tick();
    btn_u = 1'b0; btn_d = 1'b0;
    tick(3);

    // R and U same cycle: cursor move only
    btn_r = 1'b1; btn_u = 1'b1;
    tick();
    btn_r = 1'b0; btn_u = 1'b0;
    tick(3);
    chk("r_over_u_sel", int'(sel), 0);

    // stopwatch_mode with a d edge: no pulse, back to RUN
    stopwatch_mode = 1'b1; btn_d = 1'b1;
    tick();
    chk("sw_mode_editing", int'(editing), 0);
    chk("sw_mode_run", int'(run), 1);
    tick(2);
    chk("sw_mode_run_hold", int'(run), 1);
    btn_d = 1'b0;
    stopwatch_mode = 1'b0;
    tick();
    chk("reenter_edit", int'(editing), 1);
    chk("reenter_sel", int'(sel), 0);
    tick();

    // hold btn_u 20 cycles at sel=2
    press_l();
    press_l();
    chk("sel_two", int'(sel), 2);
    btn_u = 1'b1;
`ifdef WATCH_EDIT_AUTOREPEAT_EN
    expect_pulse(1,  6'b000100, 6'b0);
    expect_pulse(9,  6'b000100, 6'b0);
    expect_pulse(12, 6'b000100, 6'b0);
    expect_pulse(15, 6'b000100, 6'b0);
    expect_pulse(18, 6'b000100, 6'b0);
`else
    expect_pulse(1,  6'b000100, 6'b0);
`endif
    tick(20);
    btn_u = 1'b0;
    tick(8);
    chk("hold_release_editing", int'(editing), 1);
    chk("hold_release_sel", int'(sel), 2);

    // decrement then leave edit
    btn_d = 1'b1;
    expect_pulse(1, 6'b0, 6'b000100);
    tick();
    btn_d = 1'b0;
    tick(3);
    edit_en = 1'b0;
    tick();
    chk("exit_run", int'(run), 1);
    chk("exit_editing", int'(editing), 0);
    tick(3);

    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/watch_edit_controller.md
Name: watch_edit_controller

Overview:
- Parametrised watch control FSM: RUN (time counting) or EDIT (digit setting).
- In EDIT, a cursor moves over NUM_FIELDS digit fields; one-cycle one-hot inc/dec pulses go to the time datapath.
- Sits between the debounced button / switch inputs and the watch counter datapath; replaces the per-digit hard-coded controller.
- Optional hold-to-auto-repeat on up/down.

Parameters:
- NUM_FIELDS, 6, number of editable digit fields, min 2 (field 0 = least significant).
- SEL_W, $clog2(NUM_FIELDS), cursor width (derived, do not override).
- REPEAT_DLY, 50_000_000, cycles a held up/down must persist after its first pulse before auto-repeat starts (macro only).
- REPEAT_PER, 10_000_000, cycles between auto-repeat pulses (macro only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn_r  in  1  debounced level, cursor toward field 0
- btn_l  in  1  debounced level, cursor toward field NUM_FIELDS-1
- btn_u  in  1  debounced level, increment selected field
- btn_d  in  1  debounced level, decrement selected field
- edit_en  in  1  modify-mode switch
- stopwatch_mode  in  1  1 = display owned by stopwatch; this block idles
- run  out  1  1 = time counter enabled
- editing  out  1  1 = state is not RUN
- sel  out  SEL_W  current cursor field
- inc  out  NUM_FIELDS  one-hot increment pulse
- dec  out  NUM_FIELDS  one-hot decrement pulse

Behaviour:
- Single clock clk; rst is synchronous and active-high. All outputs are registered.
- Reset values: state=RUN, run=0, editing=0, sel=0, inc=0, dec=0, button-previous registers all 1.
  - Consequence: a button held through reset produces no edge.
  - run becomes 1 on the first clock after rst falls, provided the state stays RUN.
- Edge detect: edge_x = btn_x & ~prev_x, with prev_x registered every cycle.
- Action priority per cycle, one action max: R > L > U > D. The other edges in that cycle are discarded.
- RUN:
  - run=1, inc=dec=0.
  - edit_en=1 & stopwatch_mode=0 → EDIT next cycle, with sel←0 and run←0.
- EDIT:
  - Any cycle with edit_en=0 or stopwatch_mode=1 → RUN next cycle; no pulse that cycle. sel holds its value.
  - edge_r: sel←sel-1; 0 wraps to NUM_FIELDS-1.
  - edge_l: sel←sel+1; NUM_FIELDS-1 wraps to 0.
  - edge_u: inc[sel]=1 for exactly one cycle, in the cycle after the edge sample (latency 1).
  - edge_d: dec[sel]=1, same timing as edge_u.
- inc and dec are never both nonzero; at most one bit of either is set.
- Cursor move and pulse never occur in the same cycle.
- Rollover / carry / digit limits belong to the datapath, not this block.

Optional Feature:
- Macro: WATCH_EDIT_AUTOREPEAT_EN.
- With macro: extra states HOLD and REPEAT, plus a repeat counter of width $clog2(max(REPEAT_DLY,REPEAT_PER)+1).
  - After a U/D pulse in EDIT, go to HOLD with counter=0.
  - While the same button is held, the counter increments.
  - At REPEAT_DLY-1, emit the same pulse, go to REPEAT, counter←0.
  - In REPEAT, emit a pulse each time the counter reaches REPEAT_PER-1.
  - Button release, any other button edge, edit_en=0 or stopwatch_mode=1 → leave HOLD/REPEAT with no pulse that cycle.
    - The R/L edge is acted on.
    - Mode drop → RUN.
    - Release → EDIT.
- Without macro: only EDIT/RUN exist; a held button yields one pulse; REPEAT_* are ignored.

Decomposition:
- Package watch_ctrl_pkg:
  - state encodings ST_RUN=0, ST_EDIT=1, ST_HOLD=2, ST_REPEAT=3;
  - button index constants BTN_R=0, BTN_L=1, BTN_U=2, BTN_D=3.
- Sub-module btn_edge_detect (4-bit prev register with reset-to-ones, edge output vector).
- FSM, cursor and pulse/repeat logic live in the top.

Test Plan:
- Test parameters: NUM_FIELDS=6, REPEAT_DLY=8, REPEAT_PER=3 unless noted.
- Reset with btn_u held, edit_en=1 → after rst: EDIT, sel=0, no inc pulse until btn_u is released and re-pressed.
- EDIT, btn_r pulse at sel=0 → sel=5; then 2× btn_l → sel=1; btn_u → inc=6'b000010 for exactly one cycle, one cycle after the edge.
- btn_u and btn_d rise in the same cycle → inc only; R and U same cycle → sel move only, inc=dec=0.
- stopwatch_mode raised mid-EDIT with btn_d edge in the same cycle → no dec pulse; RUN next cycle; run=1.
- Macro on, btn_u held 20 cycles at sel=2:
  - pulses on inc[2] at relative cycles 1, 9, 12, 15, 18;
  - release → no further pulses; state EDIT.
- Macro off, same stimulus → exactly one inc[2] pulse.
